// File: rtl/ex_pkg.sv
// Shared types for the multi-cycle execute stage: ALU control codes, function
// codes, multiply/divide FSM states and datapath defaults.
package ex_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int RBITS_DEF = 5;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_NOR = 4'd5,
      ALU_SLT = 4'd6,
      ALU_MUL = 4'd7,
      ALU_DIV = 4'd8,
      ALU_SRA = 4'd9,
      ALU_INV = 4'd15
   } alu_ctrl_e;

   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_MUL  = 6'h18;
   localparam logic [5:0] FN_DIV  = 6'h1A;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } ex_state_e;

   // MUL/DIV fall back to the invalid code when the iterative unit is not built.
   function automatic alu_ctrl_e alu_decode(input logic [3:0] alu_op,
                                            input logic [5:0] funct,
                                            input bit         muldiv_en);
      alu_decode = ALU_INV;
      case (alu_op)
         4'd0: alu_decode = ALU_ADD;
         4'd1: alu_decode = ALU_SUB;
         4'd3: alu_decode = ALU_AND;
         4'd2: begin
            case (funct)
               FN_SRA:         alu_decode = ALU_SRA;
               FN_ADD, FN_ADDU: alu_decode = ALU_ADD;
               FN_SUB:         alu_decode = ALU_SUB;
               FN_AND:         alu_decode = ALU_AND;
               FN_OR:          alu_decode = ALU_OR;
               FN_XOR:         alu_decode = ALU_XOR;
               FN_NOR:         alu_decode = ALU_NOR;
               FN_SLT:         alu_decode = ALU_SLT;
               FN_MUL:         alu_decode = muldiv_en ? ALU_MUL : ALU_INV;
               FN_DIV:         alu_decode = muldiv_en ? ALU_DIV : ALU_INV;
               default:        alu_decode = ALU_INV;
            endcase
         end
         default: alu_decode = ALU_INV;
      endcase
   endfunction

endpackage

// File: rtl/ex_stage_mc_if.sv
// ID/EX inputs, WB forwarding inputs and EX/MEM outputs of the execute stage.
// master = pipeline side driving the stage, slave = the execute stage itself.
interface ex_stage_mc_if #(
   parameter int XLEN  = ex_pkg::XLEN_DEF,
   parameter int RBITS = ex_pkg::RBITS_DEF
);
   import ex_pkg::*;

   logic [XLEN-1:0]  data_1;
   logic [XLEN-1:0]  data_2;
   logic [XLEN-1:0]  imm;
   logic [RBITS-1:0] rs;
   logic [RBITS-1:0] rt;
   logic [RBITS-1:0] rd;
   logic [5:0]       ex;
   logic [2:0]       m_ex;
   logic [1:0]       wb_ex;
   logic             flush_ex;
   logic [RBITS-1:0] rd_wb;
   logic             wb_wb;
   logic [XLEN-1:0]  write_data_reg;

   logic [XLEN-1:0]  res;
   logic             zero;
   logic             over;
   logic [RBITS-1:0] write_register_ex;
   logic [XLEN-1:0]  write_data_ex;
   logic [2:0]       m_mem;
   logic [1:0]       wb_mem;
   // stall_ex: while high the upstream holds IF/ID and ID/EX unchanged; the
   // stage accepts the held instruction again in the cycle stall_ex drops.
   logic             stall_ex;
   ex_state_e        dbg_state;

   modport master (
      output data_1, data_2, imm, rs, rt, rd, ex, m_ex, wb_ex, flush_ex,
             rd_wb, wb_wb, write_data_reg,
      input  res, zero, over, write_register_ex, write_data_ex, m_mem, wb_mem,
             stall_ex, dbg_state
   );

   modport slave (
      input  data_1, data_2, imm, rs, rt, rd, ex, m_ex, wb_ex, flush_ex,
             rd_wb, wb_wb, write_data_reg,
      output res, zero, over, write_register_ex, write_data_ex, m_mem, wb_mem,
             stall_ex, dbg_state
   );

endinterface

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiplier (shift-add) / divider (restoring), one step
// per cycle over XLEN cycles; IDLE -> BUSY -> DONE -> IDLE.
module muldiv_iter
   import ex_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            is_div,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            abort,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output ex_state_e       dbg_state
);

   localparam int CW = $clog2(XLEN);

   ex_state_e       state_q;
   logic [CW-1:0]   cnt_q;
   logic            div_q;
   // MUL: acc = partial product, a = shifted multiplicand, b = remaining multiplier.
   // DIV: acc = remainder, a = divisor, b = dividend shifting out / quotient shifting in.
   logic [XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN:0]   rem_sh;
   logic [XLEN-1:0] rem_diff;
   logic            no_borrow;

   always_comb begin
      acc_d     = acc_q;
      a_d       = a_q;
      b_d       = b_q;
      rem_sh    = {acc_q, b_q[XLEN-1]};
      // A zero divisor never borrows, so every quotient bit becomes 1.
      no_borrow = (rem_sh >= {1'b0, a_q});
      rem_diff  = rem_sh[XLEN-1:0] - a_q;
      if (div_q) begin
         acc_d = no_borrow ? rem_diff : rem_sh[XLEN-1:0];
         b_d   = {b_q[XLEN-2:0], no_borrow};
      end else begin
         acc_d = acc_q + (b_q[0] ? a_q : '0);
         a_d   = {a_q[XLEN-2:0], 1'b0};
         b_d   = {1'b0, b_q[XLEN-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_BUSY;
                  cnt_q   <= CW'(XLEN - 1);
                  div_q   <= is_div;
                  acc_q   <= '0;
                  a_q     <= is_div ? op_b : op_a;
                  b_q     <= is_div ? op_a : op_b;
               end
            end
            ST_BUSY: begin
               if (abort) begin
                  state_q <= ST_IDLE;
               end else begin
                  acc_q <= acc_d;
                  a_q   <= a_d;
                  b_q   <= b_d;
                  if (cnt_q == '0) state_q <= ST_DONE;
                  else             cnt_q   <= cnt_q - CW'(1);
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy      = (state_q == ST_BUSY);
   assign done      = (state_q == ST_DONE);
   assign result    = div_q ? b_q : acc_q;
   assign dbg_state = state_q;

endmodule

// File: rtl/ex_stage_mc.sv
// MIPS execute stage: forwarding, ALU, overflow, EX/MEM register and an
// optional iterative MUL/DIV unit enabled by defining EX_MULDIV_EN.
module ex_stage_mc
   import ex_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int RBITS = RBITS_DEF
) (
   input  logic         clk,
   input  logic         rst,
   ex_stage_mc_if.slave bus
);

   localparam int SHW = $clog2(XLEN);
   localparam int MSB = XLEN - 1;
`ifdef EX_MULDIV_EN
   localparam bit MULDIV_EN = 1'b1;
`else
   localparam bit MULDIV_EN = 1'b0;
`endif

   alu_ctrl_e        ctrl;
   logic [XLEN-1:0]  fwd_a, fwd_b, op_1, op_2;
   logic [XLEN-1:0]  sum, dif, alu_res;
   logic             alu_over, is_addu;
   logic             md_done, stall;
   logic [XLEN-1:0]  md_result;
   ex_state_e        md_state;

   logic [XLEN-1:0]  res_q, res_d;
   logic             zero_q, zero_d;
   logic             over_q, over_d;
   logic [RBITS-1:0] wr_q, wr_d;
   logic [XLEN-1:0]  wd_q, wd_d;
   logic [2:0]       m_q, m_d;
   logic [1:0]       wb_q, wb_d;

   assign ctrl    = alu_decode(bus.ex[4:1], bus.imm[5:0], MULDIV_EN);
   assign is_addu = (bus.ex[4:1] == 4'd2) && (bus.imm[5:0] == FN_ADDU);

   // The instruction in EX/MEM wins over the one in WB: it is the younger producer.
   always_comb begin
      fwd_a = bus.data_1;
      if (wb_q[1] && (wr_q != '0) && (wr_q == bus.rs))
         fwd_a = res_q;
      else if (bus.wb_wb && (bus.rd_wb != '0) && (bus.rd_wb == bus.rs))
         fwd_a = bus.write_data_reg;
      fwd_b = bus.data_2;
      if (wb_q[1] && (wr_q != '0) && (wr_q == bus.rt))
         fwd_b = res_q;
      else if (bus.wb_wb && (bus.rd_wb != '0) && (bus.rd_wb == bus.rt))
         fwd_b = bus.write_data_reg;
   end

   assign op_1 = fwd_a;
   assign op_2 = bus.ex[0] ? bus.imm : fwd_b;
   assign sum  = op_1 + op_2;
   assign dif  = op_1 - op_2;

   always_comb begin
      alu_res  = '0;
      alu_over = 1'b0;
      case (ctrl)
         ALU_ADD: begin
            alu_res  = sum;
            alu_over = !is_addu && (op_1[MSB] == op_2[MSB]) && (sum[MSB] != op_1[MSB]);
         end
         ALU_SUB: begin
            alu_res  = dif;
            alu_over = (op_1[MSB] != op_2[MSB]) && (dif[MSB] != op_1[MSB]);
         end
         ALU_AND: alu_res = op_1 & op_2;
         ALU_OR:  alu_res = op_1 | op_2;
         ALU_XOR: alu_res = op_1 ^ op_2;
         ALU_NOR: alu_res = ~(op_1 | op_2);
         ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_1) < $signed(op_2))};
         ALU_SRA: alu_res = $signed(op_2) >>> op_1[SHW-1:0];
         default: alu_res = '0;
      endcase
   end

`ifdef EX_MULDIV_EN
   logic md_busy, md_start, md_is_div;

   assign md_is_div = (ctrl == ALU_DIV);
   // Issue only from IDLE; in DONE the same instruction is still held upstream.
   assign md_start  = ((ctrl == ALU_MUL) || md_is_div) && !bus.flush_ex && !md_busy && !md_done;
   assign stall     = md_start || md_busy;

   muldiv_iter #(.XLEN(XLEN)) u_muldiv (
      .clk       (clk),
      .rst       (rst),
      .start     (md_start),
      .is_div    (md_is_div),
      .op_a      (op_1),
      .op_b      (op_2),
      .abort     (bus.flush_ex),
      .busy      (md_busy),
      .done      (md_done),
      .result    (md_result),
      .dbg_state (md_state)
   );
`else
   assign md_done   = 1'b0;
   assign md_result = '0;
   assign stall     = 1'b0;
   assign md_state  = ST_IDLE;
`endif

   // A stalled cycle inserts a bubble and keeps the data fields unchanged.
   always_comb begin
      res_d  = res_q;
      zero_d = zero_q;
      over_d = over_q;
      wr_d   = wr_q;
      wd_d   = wd_q;
      m_d    = '0;
      wb_d   = '0;
      if (!stall) begin
         wr_d = bus.ex[5] ? bus.rd : bus.rt;
         wd_d = fwd_b;
         if (!bus.flush_ex) begin
            m_d  = bus.m_ex;
            wb_d = bus.wb_ex;
         end
         if (md_done) begin
            res_d  = md_result;
            over_d = 1'b0;
         end else begin
            res_d  = alu_res;
            over_d = alu_over;
         end
         zero_d = (res_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res_q  <= '0;
         zero_q <= 1'b0;
         over_q <= 1'b0;
         wr_q   <= '0;
         wd_q   <= '0;
         m_q    <= '0;
         wb_q   <= '0;
      end else begin
         res_q  <= res_d;
         zero_q <= zero_d;
         over_q <= over_d;
         wr_q   <= wr_d;
         wd_q   <= wd_d;
         m_q    <= m_d;
         wb_q   <= wb_d;
      end
   end

   assign bus.res               = res_q;
   assign bus.zero              = zero_q;
   assign bus.over              = over_q;
   assign bus.write_register_ex = wr_q;
   assign bus.write_data_ex     = wd_q;
   assign bus.m_mem             = m_q;
   assign bus.wb_mem            = wb_q;
   assign bus.stall_ex          = stall;
   assign bus.dbg_state         = md_state;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc; MUL/DIV expectations follow EX_MULDIV_EN.
module tb_ex_stage_mc;
   import ex_pkg::*;

   localparam int XLEN  = 32;
   localparam int RBITS = 5;
   localparam logic [5:0] EX_R   = 6'b1_0010_0;
   localparam logic [5:0] EX_NOP = 6'b0_0000_0;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   ex_stage_mc_if #(.XLEN(XLEN), .RBITS(RBITS)) bus ();

   ex_stage_mc #(.XLEN(XLEN), .RBITS(RBITS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic drive_op(input logic [5:0] ex_v, input logic [XLEN-1:0] imm_v,
                           input logic [4:0] rs_v, input logic [4:0] rt_v, input logic [4:0] rd_v,
                           input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                           input logic [2:0] m_v, input logic [1:0] wb_v);
      bus.ex     = ex_v;
      bus.imm    = imm_v;
      bus.rs     = rs_v;
      bus.rt     = rt_v;
      bus.rd     = rd_v;
      bus.data_1 = d1;
      bus.data_2 = d2;
      bus.m_ex   = m_v;
      bus.wb_ex  = wb_v;
   endtask

   task automatic drive_r(input logic [5:0] fn, input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2);
      drive_op(EX_R, {26'd0, fn}, 5'd1, 5'd2, 5'd3, d1, d2, 3'b000, 2'b10);
   endtask

   task automatic set_wb(input logic en, input logic [4:0] rd_v, input logic [XLEN-1:0] data);
      bus.wb_wb          = en;
      bus.rd_wb          = rd_v;
      bus.write_data_reg = data;
   endtask

   task automatic drive_nop();
      drive_op(EX_NOP, '0, 5'd0, 5'd0, 5'd0, '0, '0, 3'b000, 2'b00);
   endtask

   task automatic run_md(input string tag, input logic [5:0] fn, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp);
`ifdef EX_MULDIV_EN
      int cyc;
      logic bub_ok;
      logic [XLEN-1:0] res_before;
      res_before = bus.res;
      drive_op(EX_R, {26'd0, fn}, 5'd1, 5'd2, 5'd4, a, b, 3'b000, 2'b10);
      #1;
      cyc    = 0;
      bub_ok = 1'b1;
      while (bus.stall_ex && cyc < 200) begin
         cyc++;
         tick();
         if (bus.wb_mem != 2'b00 || bus.m_mem != 3'b000) bub_ok = 1'b0;
      end
      check_eq({tag, "_stall_cycles"}, cyc, XLEN + 1);
      check_eq({tag, "_bubble"}, bub_ok, 1'b1);
      check_eq({tag, "_res_hold"}, bus.res, res_before);
      tick();
      check_eq({tag, "_res"}, bus.res, exp);
      check_eq({tag, "_wb_mem"}, bus.wb_mem, 2'b10);
      check_eq({tag, "_wr"}, bus.write_register_ex, 5'd4);
`else
      drive_op(EX_R, {26'd0, fn}, 5'd1, 5'd2, 5'd4, a, b, 3'b000, 2'b10);
      #1;
      check_eq({tag, "_no_stall"}, bus.stall_ex, 1'b0);
      tick();
      // Without the unit MUL/DIV are invalid codes: result 0 in one cycle.
      check_eq({tag, "_res"}, bus.res, 32'h0);
      check_eq({tag, "_zero"}, bus.zero, 1'b1);
      check_eq({tag, "_wb_mem"}, bus.wb_mem, 2'b10);
      if (exp == '1) check_eq({tag, "_exp_unused"}, bus.over, 1'b0);
`endif
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      rst         = 1'b1;
      bus.flush_ex = 1'b0;
      drive_nop();
      set_wb(1'b0, 5'd0, '0);
      tick();
      tick();

      // reset state
      check_eq("rst_res", bus.res, 32'h0);
      check_eq("rst_zero", bus.zero, 1'b0);
      check_eq("rst_over", bus.over, 1'b0);
      check_eq("rst_wr", bus.write_register_ex, 5'd0);
      check_eq("rst_wd", bus.write_data_ex, 32'h0);
      check_eq("rst_m", bus.m_mem, 3'b000);
      check_eq("rst_wb", bus.wb_mem, 2'b00);
      check_eq("rst_stall", bus.stall_ex, 1'b0);
      check_eq("rst_state", bus.dbg_state, ST_IDLE);
      rst = 1'b0;

      // overflow and the basic ALU functions
      drive_r(FN_ADD, 32'h7FFF_FFFF, 32'h1);
      tick();
      check_eq("add_ovf_res", bus.res, 32'h8000_0000);
      check_eq("add_ovf_over", bus.over, 1'b1);
      check_eq("add_wr", bus.write_register_ex, 5'd3);
      check_eq("add_wd", bus.write_data_ex, 32'h1);
      check_eq("add_wb", bus.wb_mem, 2'b10);

      drive_r(FN_ADDU, 32'h7FFF_FFFF, 32'h1);
      tick();
      check_eq("addu_res", bus.res, 32'h8000_0000);
      check_eq("addu_over", bus.over, 1'b0);

      drive_r(FN_SUB, 32'h8000_0000, 32'h1);
      tick();
      check_eq("sub_ovf_res", bus.res, 32'h7FFF_FFFF);
      check_eq("sub_ovf_over", bus.over, 1'b1);

      drive_r(FN_SUB, 32'h5, 32'h7);
      tick();
      check_eq("sub_neg_res", bus.res, 32'hFFFF_FFFE);
      check_eq("sub_neg_over", bus.over, 1'b0);

      drive_r(FN_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
      tick();
      check_eq("and_res", bus.res, 32'h00F0_1200);
      drive_r(FN_OR, 32'hF0F0_1234, 32'h0FF0_FF00);
      tick();
      check_eq("or_res", bus.res, 32'hFFF0_FF34);
      drive_r(FN_XOR, 32'hF0F0_1234, 32'h0FF0_FF00);
      tick();
      check_eq("xor_res", bus.res, 32'hFF00_ED34);
      drive_r(FN_NOR, 32'hF0F0_1234, 32'h0FF0_FF00);
      tick();
      check_eq("nor_res", bus.res, 32'h000F_00CB);
      check_eq("nor_zero", bus.zero, 1'b0);

      drive_r(FN_SLT, 32'hFFFF_FFFF, 32'h1);
      tick();
      check_eq("slt_neg_res", bus.res, 32'h1);
      drive_r(FN_SLT, 32'h5, 32'h3);
      tick();
      check_eq("slt_ge_res", bus.res, 32'h0);
      check_eq("slt_ge_zero", bus.zero, 1'b1);

      drive_r(FN_SRA, 32'h4, 32'h8000_0010);
      tick();
      check_eq("sra_res", bus.res, 32'hF800_0001);

      // immediate operand, rt destination, memory controls
      drive_op(6'b0_0000_1, 32'hFFFF_FFFC, 5'd1, 5'd8, 5'd3, 32'd10, 32'd77, 3'b010, 2'b11);
      tick();
      check_eq("imm_res", bus.res, 32'd6);
      check_eq("imm_wr", bus.write_register_ex, 5'd8);
      check_eq("imm_wd", bus.write_data_ex, 32'd77);
      check_eq("imm_m", bus.m_mem, 3'b010);
      check_eq("imm_wb", bus.wb_mem, 2'b11);

      drive_op(6'b1_0101_0, 32'h0, 5'd1, 5'd2, 5'd3, 32'd3, 32'd4, 3'b000, 2'b10);
      tick();
      check_eq("inv_res", bus.res, 32'h0);
      check_eq("inv_zero", bus.zero, 1'b1);

      drive_op(6'b0_0001_0, 32'h0, 5'd1, 5'd2, 5'd3, 32'd10, 32'd10, 3'b100, 2'b00);
      tick();
      check_eq("beq_res", bus.res, 32'h0);
      check_eq("beq_zero", bus.zero, 1'b1);
      check_eq("beq_m", bus.m_mem, 3'b100);

      drive_op(EX_R, {26'd0, FN_ADD}, 5'd1, 5'd2, 5'd3, 32'd1, 32'd1, 3'b111, 2'b11);
      bus.flush_ex = 1'b1;
      tick();
      check_eq("flush_m", bus.m_mem, 3'b000);
      check_eq("flush_wb", bus.wb_mem, 2'b00);
      bus.flush_ex = 1'b0;

      // forwarding priority
      drive_op(EX_R, {26'd0, FN_ADD}, 5'd1, 5'd2, 5'd5, 32'd4, 32'd6, 3'b000, 2'b10);
      tick();
      check_eq("fwd_src_res", bus.res, 32'd10);
      drive_op(EX_R, {26'd0, FN_ADD}, 5'd5, 5'd6, 5'd9, 32'd999, 32'd1, 3'b000, 2'b10);
      set_wb(1'b1, 5'd5, 32'd20);
      tick();
      check_eq("fwd_mem_prio", bus.res, 32'd11);
      check_eq("fwd_mem_wd", bus.write_data_ex, 32'd1);
      set_wb(1'b0, 5'd0, '0);
      drive_op(EX_R, {26'd0, FN_ADD}, 5'd7, 5'd8, 5'd0, 32'd1, 32'd2, 3'b000, 2'b10);
      tick();
      check_eq("fwd_r0_src", bus.res, 32'd3);
      drive_op(EX_R, {26'd0, FN_ADD}, 5'd5, 5'd6, 5'd0, 32'd999, 32'd1, 3'b000, 2'b10);
      set_wb(1'b1, 5'd5, 32'd20);
      tick();
      check_eq("fwd_wb_only", bus.res, 32'd21);
      set_wb(1'b0, 5'd0, '0);
      drive_op(EX_R, {26'd0, FN_ADD}, 5'd0, 5'd6, 5'd10, 32'd0, 32'd1, 3'b000, 2'b10);
      tick();
      check_eq("fwd_r0_never", bus.res, 32'd1);
      drive_op(EX_R, {26'd0, FN_ADD}, 5'd10, 5'd5, 5'd11, 32'd999, 32'd999, 3'b000, 2'b10);
      set_wb(1'b1, 5'd5, 32'd20);
      tick();
      check_eq("fwd_both_res", bus.res, 32'd21);
      check_eq("fwd_both_wd", bus.write_data_ex, 32'd20);
      set_wb(1'b0, 5'd0, '0);
      drive_nop();
      tick();

      // multiply / divide
      run_md("mul7x6", FN_MUL, 32'd7, 32'd6, 32'd42);
      run_md("div100_0", FN_DIV, 32'd100, 32'd0, 32'hFFFF_FFFF);
      run_md("div100_7", FN_DIV, 32'd100, 32'd7, 32'd14);

      // flush while the unit is busy
      drive_op(EX_R, {26'd0, FN_MUL}, 5'd1, 5'd2, 5'd7, 32'd3, 32'd5, 3'b001, 2'b10);
`ifdef EX_MULDIV_EN
      begin
         logic [XLEN-1:0] res_before;
         logic            clean;
         res_before = bus.res;
         tick();
         tick();
         tick();
         bus.flush_ex = 1'b1;
         #1;
         check_eq("mflush_busy_stall", bus.stall_ex, 1'b1);
         tick();
         check_eq("mflush_m", bus.m_mem, 3'b000);
         check_eq("mflush_wb", bus.wb_mem, 2'b00);
         check_eq("mflush_res_hold", bus.res, res_before);
         check_eq("mflush_state", bus.dbg_state, ST_IDLE);
         bus.flush_ex = 1'b0;
         drive_nop();
         #1;
         check_eq("mflush_stall_drop", bus.stall_ex, 1'b0);
         clean = 1'b1;
         for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.res == 32'd15 || bus.wb_mem != 2'b00) clean = 1'b0;
         end
         check_eq("mflush_no_result", clean, 1'b1);
      end
`else
      bus.flush_ex = 1'b1;
      #1;
      check_eq("mflush_stall", bus.stall_ex, 1'b0);
      tick();
      check_eq("mflush_m", bus.m_mem, 3'b000);
      check_eq("mflush_wb", bus.wb_mem, 2'b00);
      bus.flush_ex = 1'b0;
      drive_nop();
      tick();
`endif

      // reset during a divide
      drive_op(EX_R, {26'd0, FN_DIV}, 5'd1, 5'd2, 5'd4, 32'd100, 32'd7, 3'b000, 2'b10);
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive_r(FN_ADD, 32'd2, 32'd3);
      #1;
      check_eq("rdiv_stall", bus.stall_ex, 1'b0);
      check_eq("rdiv_state", bus.dbg_state, ST_IDLE);
      check_eq("rdiv_res", bus.res, 32'h0);
      check_eq("rdiv_zero", bus.zero, 1'b0);
      check_eq("rdiv_over", bus.over, 1'b0);
      check_eq("rdiv_wr", bus.write_register_ex, 5'd0);
      check_eq("rdiv_wd", bus.write_data_ex, 32'h0);
      check_eq("rdiv_m", bus.m_mem, 3'b000);
      check_eq("rdiv_wb", bus.wb_mem, 2'b00);
      tick();
      check_eq("rdiv_add_res", bus.res, 32'd5);

      // final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
